// File: rtl/maze_playfield.sv
// Writable 40x30 tile-map playfield with per-scanline row prefetch.
// Define MAZE_BORDER_EN to force the outer ring of tiles to read as walls.
module maze_playfield #(
    parameter int H_ACTIVE  = 640,
    parameter int V_TOTAL   = 525,
    parameter int TILE_COLS = 40,
    parameter int TILE_ROWS = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       display_on,
    input  logic       wr_en,
    input  logic [4:0] wr_row,
    input  logic [5:0] wr_col,
    input  logic       wr_data,
    output logic       playfield,
    output logic       busy
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t               state, state_nxt;
    logic [4:0]           row_cnt, row_cnt_nxt;
    logic [TILE_COLS-1:0] map [TILE_ROWS];
    logic [TILE_COLS-1:0] rowbuf;
    logic [TILE_COLS-1:0] init_row;
    logic [TILE_COLS-1:0] fetch_row;
    logic [63:0]          rowbuf_ext;
    logic [9:0]           vnext;
    logic [4:0]           frow;
    logic [5:0]           col;
    logic                 fetch;
    logic                 wr_ok;
    logic                 pix;

    always_comb begin
        state_nxt   = state;
        row_cnt_nxt = row_cnt;
        busy        = (state == CLEAR);
        unique case (state)
            CLEAR: begin
                row_cnt_nxt = row_cnt + 5'd1;
                if (row_cnt == 5'(TILE_ROWS - 1)) begin
                    state_nxt   = RUN;
                    row_cnt_nxt = '0;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Reproduces the legacy 32-px checker: wall where row bit 1 and col bit 1
    always_comb begin
        init_row = '0;
        for (int c = 0; c < TILE_COLS; c++) begin
            init_row[c] = row_cnt[1] & ((c & 2) != 0);
        end
    end

    always_comb begin
        vnext = (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
        frow  = 5'(vnext >> 4);
        fetch = (state == RUN) && (hpos == 10'(H_ACTIVE));
        fetch_row = '0;
        if (vnext < 10'(TILE_ROWS * 16)) begin
            fetch_row = map[frow];
`ifdef MAZE_BORDER_EN
            if (frow == 5'd0 || frow == 5'(TILE_ROWS - 1)) begin
                fetch_row = '1;
            end
            fetch_row[0]           = 1'b1;
            fetch_row[TILE_COLS-1] = 1'b1;
`endif
        end
    end

    always_comb begin
        col        = 6'(hpos >> 4);
        rowbuf_ext = 64'(rowbuf);
        pix        = display_on && (col < 6'(TILE_COLS)) && rowbuf_ext[col];
        wr_ok      = (state == RUN) && wr_en &&
                     (wr_row < 5'(TILE_ROWS)) && (wr_col < 6'(TILE_COLS));
    end

    // Map storage is deliberately not reset; CLEAR rewrites every row
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            map[row_cnt] <= init_row;
        end else if (wr_ok) begin
            map[wr_row][wr_col] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= CLEAR;
            row_cnt   <= '0;
            rowbuf    <= '0;
            playfield <= 1'b0;
        end else begin
            state     <= state_nxt;
            row_cnt   <= row_cnt_nxt;
            if (fetch) begin
                rowbuf <= fetch_row;
            end
            playfield <= (state == RUN) && pix;
        end
    end

endmodule
